spi_memory_fsm: RTL and testbench

//  Sequencing controller for the SPI memory datapath: drives the shift register's parallel-load, the

---
 rtl/spi_fsm_pkg.sv | 24 ++
 rtl/spi_bit_counter.sv | 31 +++
 rtl/spi_memory_fsm.sv | 158 +++++++++++++++
 tb/tb_spi_memory_fsm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_fsm_pkg
// Purpose  : State encoding and shared constants for the SPI memory sequencer.
// Revision : 1.0
// ============================================================================
package spi_fsm_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        GET_ADDR     = 4'd1,
        GOT_ADDR     = 4'd2,
        READ_WAIT    = 4'd3,
        READ_LOAD    = 4'd4,
        READ_SHIFT   = 4'd5,
        WRITE_GET    = 4'd6,
        WRITE_COMMIT = 4'd7,
        DONE         = 4'd8
    } state_t;

    localparam logic RW_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bit_counter
// Purpose  : Clearable up-counter with terminal-count compare; holds at terminal.
// Revision : 1.0
// ============================================================================
module spi_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_terminal,
    output logic             o_atTerminal
);
    logic [CNT_W-1:0] r_count;

    // Holding at terminal keeps the count from ever wrapping inside a frame.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !o_atTerminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_atTerminal = (r_count == i_terminal);

endmodule
`default_nettype wire

// File: rtl/spi_memory_fsm.sv
`default_nettype none
// ============================================================================
// Module   : spi_memory_fsm
// Purpose  : Sequences address latch, memory load/write strobes and MISO enable
//            for one SPI frame. SPI_FSM_TIMEOUT_EN adds an SCLK watchdog.
// Revision : 1.0
// ============================================================================
module spi_memory_fsm
    import spi_fsm_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ADDR_BITS   = 7,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_rise,
    input  logic sclk_fall,
    input  logic rw_bit,
    output logic sr_parallel_load,
    output logic addr_we,
    output logic dm_we,
    output logic miso_buff_en,
    output logic busy
`ifdef SPI_FSM_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);
    localparam int unsigned        c_bitMax   = (WIDTH > ADDR_BITS + 1) ? WIDTH : ADDR_BITS + 1;
    localparam int unsigned        c_cntW     = $clog2(c_bitMax + 1);
    localparam int unsigned        c_latW     = $clog2(MEM_LATENCY + 1);
    localparam logic [c_cntW-1:0]  c_addrLast = c_cntW'(ADDR_BITS);
    localparam logic [c_cntW-1:0]  c_dataLast = c_cntW'(WIDTH - 1);
    localparam logic [c_latW-1:0]  c_latLast  = c_latW'(MEM_LATENCY - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_addrWe, r_srLoad, r_dmWe, r_misoEn, r_busy;
    logic                w_stateChange, w_bitInc, w_bitAtTerm, w_latAtTerm;
    logic                w_timeout, w_armed;
    logic [c_cntW-1:0]   w_bitTerm;

    assign w_stateChange = (w_nextState != r_state);
    assign w_bitInc      = (((r_state == GET_ADDR) || (r_state == WRITE_GET)) && sclk_rise)
                         || ((r_state == READ_SHIFT) && sclk_fall);
    assign w_bitTerm     = (r_state == GET_ADDR) ? c_addrLast : c_dataLast;

    // Every state change restarts the count, so each phase begins at zero.
    spi_bit_counter #(.CNT_W(c_cntW)) u_bitCnt (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_stateChange),
        .i_inc        (w_bitInc),
        .i_terminal   (w_bitTerm),
        .o_atTerminal (w_bitAtTerm)
    );

    spi_bit_counter #(.CNT_W(c_latW)) u_latCnt (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_stateChange),
        .i_inc        (r_state == READ_WAIT),
        .i_terminal   (c_latLast),
        .o_atTerminal (w_latAtTerm)
    );

`ifdef SPI_FSM_TIMEOUT_EN
    localparam int unsigned       c_wdW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_wdW-1:0]  c_wdLast = c_wdW'(TIMEOUT_CYC - 1);

    logic w_watched, w_sclkEdge, w_wdAtTerm, r_csArmed, r_timeoutErr;

    assign w_watched  = (r_state == GET_ADDR) || (r_state == READ_SHIFT) || (r_state == WRITE_GET);
    assign w_sclkEdge = sclk_rise | sclk_fall;

    spi_bit_counter #(.CNT_W(c_wdW)) u_watchdog (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (!w_watched || w_sclkEdge),
        .i_inc        (1'b1),
        .i_terminal   (c_wdLast),
        .o_atTerminal (w_wdAtTerm)
    );

    // Fires on the TIMEOUT_CYC-th consecutive edge-free cycle; cs_n abort takes precedence.
    assign w_timeout   = w_watched && !w_sclkEdge && w_wdAtTerm && !cs_n;
    assign w_armed     = r_csArmed;
    assign timeout_err = r_timeoutErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csArmed    <= 1'b1;
            r_timeoutErr <= 1'b0;
        end else begin
            r_timeoutErr <= w_timeout;
            if (cs_n) begin
                r_csArmed <= 1'b1;
            end else if (w_timeout) begin
                r_csArmed <= 1'b0;
            end
        end
    end
`else
    localparam int unsigned c_unusedTimeoutCyc = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
    assign w_armed   = 1'b1;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:         if (!cs_n && w_armed) w_nextState = GET_ADDR;
            GET_ADDR:     if (sclk_rise && w_bitAtTerm) w_nextState = GOT_ADDR;
            GOT_ADDR:     w_nextState = (rw_bit == RW_READ) ? READ_WAIT : WRITE_GET;
            READ_WAIT:    if (w_latAtTerm) w_nextState = READ_LOAD;
            READ_LOAD:    w_nextState = READ_SHIFT;
            READ_SHIFT:   if (sclk_fall && w_bitAtTerm) w_nextState = DONE;
            WRITE_GET:    if (sclk_rise && w_bitAtTerm) w_nextState = WRITE_COMMIT;
            WRITE_COMMIT: w_nextState = DONE;
            DONE:         w_nextState = DONE;
            default:      w_nextState = IDLE;
        endcase
        if ((r_state != IDLE) && (cs_n || w_timeout)) begin
            w_nextState = IDLE;
        end
    end

    // Strobes are decoded from the next state so they align with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addrWe <= 1'b0;
            r_srLoad <= 1'b0;
            r_dmWe   <= 1'b0;
            r_misoEn <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_addrWe <= (w_nextState == GOT_ADDR);
            r_srLoad <= (w_nextState == READ_LOAD);
            r_dmWe   <= (w_nextState == WRITE_COMMIT);
            r_misoEn <= (w_nextState == READ_SHIFT);
            r_busy   <= (w_nextState != IDLE);
        end
    end

    assign addr_we          = r_addrWe;
    assign sr_parallel_load = r_srLoad;
    assign dm_we            = r_dmWe;
    assign miso_buff_en     = r_misoEn;
    assign busy             = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_memory_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_memory_fsm
// Purpose  : Frame-level checker for spi_memory_fsm; optional SPI_FSM_TIMEOUT_EN section.
// Revision : 1.0
// ============================================================================
module tb_spi_memory_fsm;
    localparam int WIDTH       = 8;
    localparam int ADDR_BITS   = 7;
    localparam int HDR         = ADDR_BITS + 1;
    localparam int MEM_LATENCY = 1;
    localparam int TIMEOUT_CYC = 16;
    localparam int MAXC        = 512;

    logic clk = 1'b0;
    logic reset, cs_n, sclk_rise, sclk_fall, rw_bit;
    logic sr_parallel_load, addr_we, dm_we, miso_buff_en, busy;
`ifdef SPI_FSM_TIMEOUT_EN
    logic timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    logic sCs [MAXC];
    logic sRise [MAXC];
    logic sFall [MAXC];
    logic sRw [MAXC];
    logic sRst [MAXC];
    logic eAddr [MAXC];
    logic eLoad [MAXC];
    logic eDm [MAXC];
    logic eBuf [MAXC];
    logic eBusy [MAXC];
    logic eTo [MAXC];
    logic rwNow = 1'b0;

    always #5 clk = ~clk;

    spi_memory_fsm #(
        .WIDTH       (WIDTH),
        .ADDR_BITS   (ADDR_BITS),
        .MEM_LATENCY (MEM_LATENCY),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cs_n             (cs_n),
        .sclk_rise        (sclk_rise),
        .sclk_fall        (sclk_fall),
        .rw_bit           (rw_bit),
        .sr_parallel_load (sr_parallel_load),
        .addr_we          (addr_we),
        .dm_we            (dm_we),
        .miso_buff_en     (miso_buff_en),
        .busy             (busy)
`ifdef SPI_FSM_TIMEOUT_EN
        ,
        .timeout_err      (timeout_err)
`endif
    );

    task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic clearSchedule();
        for (int k = 0; k < MAXC; k++) begin
            sCs[k] = 1'b0; sRise[k] = 1'b0; sFall[k] = 1'b0; sRw[k] = 1'b0; sRst[k] = 1'b0;
            eAddr[k] = 1'b0; eLoad[k] = 1'b0; eDm[k] = 1'b0; eBuf[k] = 1'b0;
            eBusy[k] = 1'b0; eTo[k] = 1'b0;
        end
    endtask

    // Cycle of the nth SCLK edge of one kind in [from, lim], or -1.
    function automatic int nthEdge(input bit isRise, input int from, input int lim, input int nth);
        int seen = 0;
        for (int k = from; k <= lim; k++) begin
            if ((isRise ? sRise[k] : sFall[k]) === 1'b1) begin
                seen++;
                if (seen == nth) return k;
            end
        end
        return -1;
    endfunction

    task automatic playFrame(input int last);
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            cs_n      = sCs[k];
            sclk_rise = sRise[k];
            sclk_fall = sFall[k];
            rw_bit    = sRw[k];
            reset     = sRst[k];
            @(negedge clk);
            check("addr_we", k, addr_we, eAddr[k]);
            check("sr_parallel_load", k, sr_parallel_load, eLoad[k]);
            check("dm_we", k, dm_we, eDm[k]);
            check("miso_buff_en", k, miso_buff_en, eBuf[k]);
            check("busy", k, busy, eBusy[k]);
`ifdef SPI_FSM_TIMEOUT_EN
            check("timeout_err", k, timeout_err, eTo[k]);
`endif
        end
    endtask

    // cutKind: 0 = normal end with cs_n high, 1 = cs_n abort after 12 bits, 2 = reset mid data phase.
    task automatic runFrame(input bit isRead, input logic [ADDR_BITS-1:0] addr,
                            input logic [WIDTH-1:0] data, input int cutKind, input bit extraEdges);
        logic [HDR+WIDTH-1:0] bits;
        int cur, fallAt, lastEdge, e, h, f, w, shiftStart, cutAt, bi;
        bits = {addr, isRead, data};
        clearSchedule();
        cur = 1 + int'($urandom_range(0, 2));
        lastEdge = 0;
        cutAt = -1;
        for (int i = 0; i < HDR + WIDTH; i++) begin
            if (i == HDR) cur += MEM_LATENCY + 3 + int'($urandom_range(0, 2));
            sRise[cur] = 1'b1;
            if (cutKind == 1 && i == 11) cutAt = cur + 1;
            fallAt = cur + 2 + int'($urandom_range(0, 1));
            sFall[fallAt] = 1'b1;
            lastEdge = fallAt;
            cur = fallAt + 1 + int'($urandom_range(1, 2));
        end
        if (extraEdges) begin
            sRise[lastEdge + 3] = 1'b1;
            sFall[lastEdge + 4] = 1'b1;
            lastEdge += 4;
        end

        // Header completes on the HDR-th rise seen after chip select drops.
        h = nthEdge(1'b1, 1, MAXC - 1, HDR);
        shiftStart = h + 3 + MEM_LATENCY;
        if (cutKind == 1) begin
            e = cutAt;
            sCs[e] = 1'b1;
        end else if (cutKind == 2) begin
            e = shiftStart + 2;
            sRst[e] = 1'b1;
        end else begin
            e = lastEdge + 2 + int'($urandom_range(0, 3));
            sCs[e] = 1'b1;
        end

        bi = 0;
        for (int k = 0; k <= e; k++) begin
            sRw[k] = rwNow;
            if (sRise[k] && bi < HDR + WIDTH) begin
                rwNow = bits[HDR + WIDTH - 1 - bi];
                bi++;
            end
        end

        for (int k = 1; k <= e; k++) eBusy[k] = 1'b1;
        if (h + 1 <= e) eAddr[h + 1] = 1'b1;
        if (isRead) begin
            if (h + 2 + MEM_LATENCY <= e) eLoad[h + 2 + MEM_LATENCY] = 1'b1;
            f = nthEdge(1'b0, shiftStart, e, WIDTH);
            for (int k = shiftStart; k <= ((f < 0) ? e : f); k++) eBuf[k] = 1'b1;
        end else begin
            w = nthEdge(1'b1, h + 2, e, WIDTH);
            if (w >= 0 && w + 1 <= e) eDm[w + 1] = 1'b1;
        end
        playFrame(e);
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; rw_bit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset addr_we", 0, addr_we, 1'b0);
        check("reset sr_parallel_load", 0, sr_parallel_load, 1'b0);
        check("reset dm_we", 0, dm_we, 1'b0);
        check("reset miso_buff_en", 0, miso_buff_en, 1'b0);
        check("reset busy", 0, busy, 1'b0);

        runFrame(1'b0, 7'b0000011, 8'b10011010, 0, 1'b1);
        runFrame(1'b1, 7'b0000011, 8'h00, 0, 1'b1);
        runFrame(1'b0, 7'd3, 8'hA5, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            runFrame(1'($urandom_range(0, 1)), ADDR_BITS'($urandom), WIDTH'($urandom), 0,
                     1'($urandom_range(0, 1)));
        end
        runFrame(1'b1, 7'd3, 8'h3C, 2, 1'b0);
        runFrame(1'b0, 7'd5, 8'h5A, 0, 1'b0);

`ifdef SPI_FSM_TIMEOUT_EN
        // Three header bits, then silence: 16 edge-free cycles after the last fall at 12.
        clearSchedule();
        for (int i = 0; i < 3; i++) begin
            sRise[2 + 4 * i] = 1'b1;
            sFall[4 + 4 * i] = 1'b1;
        end
        for (int k = 1; k <= 28; k++) eBusy[k] = 1'b1;
        eTo[29] = 1'b1;
        sCs[40] = 1'b1;
        for (int k = 42; k <= 45; k++) eBusy[k] = 1'b1;
        playFrame(45);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
